lcd_text_driver: RTL and testbench

Parametrised HD44780-compatible character-LCD driver for 1-, 2- or 4-line panels in 8-bit mode. It holds an internal text buffer that the host writes one character at a time. It runs the power-up and init sequence once, then redraws the whole panel whenever the buffer changes or a refresh is requested. It sits between the clock/status formatting logic and the LCD pins, and replaces the fixed 2x16 free-running refresh loop with a dirty-driven, correctly timed bus.

---
 rtl/lcd_text_driver.sv | 236 +++++++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// lcd_text_driver: HD44780 8-bit character LCD driver with an internal
// text buffer, one-shot init sequence and dirty-driven full redraws.
module lcd_text_driver #(
  parameter int TICK_CYCLES      = 2500,
  parameter int POWERUP_TICKS    = 800,
  parameter int CLEAR_WAIT_TICKS = 40,
  parameter int NUM_LINES        = 2,
  parameter int NUM_COLS         = 16,
  localparam int DEPTH = NUM_LINES * NUM_COLS,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          refresh,
  output logic          busy,
  output logic          frame_done,
  output logic          rs,
  output logic          rw,
  output logic          enable,
  output logic [7:0]    data
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int M1 = (POWERUP_TICKS > CLEAR_WAIT_TICKS) ?
                      POWERUP_TICKS : CLEAR_WAIT_TICKS;
  localparam int CMAX = (M1 > NUM_COLS) ? M1 : NUM_COLS;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [2:0] S_PWR  = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_CLR  = 3'd2;
  localparam logic [2:0] S_IDLE = 3'd3;
  localparam logic [2:0] S_SET  = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_PULSE = 2'd1;
  localparam logic [1:0] PH_HOLD  = 2'd2;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] line_q, line_d;
  logic          dirty_q, dirty_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    buf_d [DEPTH];

  logic          tick_end;
  logic          dirty_set, dirty_clr, dirty_force;
  logic          ld, ld_rs;
  logic [7:0]    ld_byte;
  logic [AW-1:0] rd_addr;

  function automatic logic [7:0] init_cmd(input int i);
    unique case (i)
      0:       return 8'h38;
      1:       return 8'h06;
      2:       return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Odd lines live at 0x40, lines 2/3 continue one row-width further on.
  function automatic logic [7:0] line_cmd(input logic [LW-1:0] l);
    int li;
    logic [7:0] b;
    li = int'(l);
    b  = li[0] ? 8'h40 : 8'h00;
    if (li[1]) b = b + 8'(NUM_COLS);
    return 8'h80 | b;
  endfunction

  assign tick_end = (tick_q == TW'(TICK_CYCLES - 1));

  // Host writes land in any state; out-of-range addresses are dropped.
  always_comb begin
    buf_d     = buf_q;
    dirty_set = refresh;
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      buf_d[wr_addr] = wr_data;
      dirty_set      = 1'b1;
    end
  end

  // Sequencer: waits, init commands, and the line/column redraw walk.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_end ? '0 : tick_q + TW'(1);
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    rs_d        = rs_q;
    data_d      = data_q;
    dirty_clr   = 1'b0;
    dirty_force = 1'b0;
    ld          = 1'b0;
    ld_rs       = 1'b0;
    ld_byte     = 8'h00;
    rd_addr     = AW'(int'(line_q) * NUM_COLS +
                  ((state_q == S_WR) ? int'(cnt_q) + 1 : 0));
    unique case (state_q)
      S_PWR: if (tick_end) begin
        if (cnt_q == CW'(POWERUP_TICKS - 1)) begin
          state_d = S_INIT;
          cnt_d   = '0;
          ld      = 1'b1;
          ld_byte = init_cmd(0);
        end else cnt_d = cnt_q + CW'(1);
      end
      S_INIT: if (tick_end) begin
        if (phase_q != PH_HOLD) phase_d = phase_q + 2'd1;
        else if (cnt_q == CW'(3)) begin
          state_d = S_CLR;
          cnt_d   = '0;
          phase_d = PH_SETUP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          ld      = 1'b1;
          ld_byte = init_cmd(int'(cnt_q) + 1);
        end
      end
      S_CLR: if (tick_end) begin
        if (cnt_q == CW'(CLEAR_WAIT_TICKS - 1)) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          dirty_force = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_IDLE: begin
        tick_d = '0;
        if (dirty_q) begin
          state_d   = S_SET;
          line_d    = '0;
          dirty_clr = 1'b1;
          ld        = 1'b1;
          ld_byte   = line_cmd('0);
        end
      end
      S_SET: if (tick_end) begin
        if (phase_q != PH_HOLD) phase_d = phase_q + 2'd1;
        else begin
          state_d = S_WR;
          cnt_d   = '0;
          ld      = 1'b1;
          ld_rs   = 1'b1;
          ld_byte = buf_q[rd_addr];
        end
      end
      S_WR: if (tick_end) begin
        if (phase_q != PH_HOLD) phase_d = phase_q + 2'd1;
        else if (cnt_q == CW'(NUM_COLS - 1)) begin
          cnt_d   = '0;
          phase_d = PH_SETUP;
          if (line_q == LW'(NUM_LINES - 1)) state_d = S_DONE;
          else begin
            state_d = S_SET;
            line_d  = line_q + LW'(1);
            ld      = 1'b1;
            ld_byte = line_cmd(line_q + LW'(1));
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          ld      = 1'b1;
          ld_rs   = 1'b1;
          ld_byte = buf_q[rd_addr];
        end
      end
      S_DONE: begin
        tick_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_PWR;
    endcase
    if (ld) begin
      tick_d  = '0;
      phase_d = PH_SETUP;
      rs_d    = ld_rs;
      data_d  = ld_byte;
    end
    dirty_d  = dirty_set | dirty_force | (dirty_q & ~dirty_clr);
    enable_d = (state_d == S_INIT || state_d == S_SET ||
                state_d == S_WR) && (phase_d == PH_PULSE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  // State, bus pins and the text buffer all register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_PWR;
      tick_q   <= '0;
      phase_q  <= PH_SETUP;
      cnt_q    <= '0;
      line_q   <= '0;
      dirty_q  <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      enable_q <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h20;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      dirty_q  <= dirty_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      buf_q    <= buf_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign rs         = rs_q;
  assign rw         = 1'b0;
  assign enable     = enable_q;
  assign data       = data_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// tb_lcd_text_driver: directed bench, transfer scoreboard on the LCD bus,
// plus a 4x20 instance for geometry and out-of-range writes.
module tb_lcd_text_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, wr_en = 1'b0, refresh = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       busy, frame_done, rs, rw, enable;
  logic [7:0] data;

  logic       rst4 = 1'b1, wr_en4 = 1'b0, refresh4 = 1'b0;
  logic [6:0] wr_addr4 = '0;
  logic [7:0] wr_data4 = '0;
  logic       busy4, frame_done4, rs4, rw4, enable4;
  logic [7:0] data4;

  lcd_text_driver #(
    .TICK_CYCLES(4), .POWERUP_TICKS(2), .CLEAR_WAIT_TICKS(3),
    .NUM_LINES(2), .NUM_COLS(4)
  ) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .refresh(refresh), .busy(busy),
    .frame_done(frame_done), .rs(rs), .rw(rw), .enable(enable),
    .data(data)
  );

  lcd_text_driver #(
    .TICK_CYCLES(2), .POWERUP_TICKS(1), .CLEAR_WAIT_TICKS(1),
    .NUM_LINES(4), .NUM_COLS(20)
  ) u_dut4 (
    .clk(clk), .rst(rst4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .refresh(refresh4), .busy(busy4),
    .frame_done(frame_done4), .rs(rs4), .rw(rw4), .enable(enable4),
    .data(data4)
  );

  int checks = 0, failures = 0;
  logic [8:0] exp_q[$];
  logic [7:0] exp4[$];
  logic [7:0] mdl [8];
  logic       prev_en, stable, prev4;
  logic [8:0] rise_byte;
  int         en_w, xfer4 = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_frame();
    for (int l = 0; l < 2; l++) begin
      exp_q.push_back({1'b0, 8'h80 + 8'(l * 8'h40)});
      for (int c = 0; c < 4; c++) exp_q.push_back({1'b1, mdl[l*4+c]});
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (frame_done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, frame_done, 1);
  endtask

  // Pop one expected byte per E rising edge; check E width/stability.
  always @(negedge clk) begin
    if (enable === 1'b1 && prev_en !== 1'b1) begin
      en_w      = 1;
      stable    = 1'b1;
      rise_byte = {rs, data};
      chk("sb_has_entry", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("xfer", {rs, data}, exp_q.pop_front());
      chk("rw_low", rw, 0);
    end else if (enable === 1'b1) begin
      en_w++;
      if ({rs, data} !== rise_byte) stable = 1'b0;
    end else if (prev_en === 1'b1 && rst === 1'b0) begin
      chk("e_width", en_w, 4);
      chk("e_stable", stable, 1);
    end
    prev_en = enable;
  end

  // 4-line instance: count transfers, compare line commands.
  always @(negedge clk) begin
    if (enable4 === 1'b1 && prev4 !== 1'b1) begin
      xfer4++;
      if (rs4 === 1'b0 && data4[7] === 1'b1) begin
        chk("line_cmd4_has", exp4.size() > 0, 1);
        if (exp4.size() > 0) chk("line_cmd4", data4, exp4.pop_front());
      end
    end
    prev4 = enable4;
  end

  initial begin
    int n;
    logic seen;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h20;
    @(negedge clk);
    @(negedge clk);
    chk("rst_vals", {rs, enable, busy, frame_done, data}, 12'h200);
    push_init();
    push_frame();
    rst = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("pwr_quiet", {enable, data}, 0);
    end
    @(negedge clk);
    chk("first_cmd", {enable, rs, data}, 10'h038);
    wait_done("frame1_done", 1000);
    @(negedge clk);
    chk("busy_after_f1", {busy, frame_done}, 0);

    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    mdl[5] = 8'h41;
    push_frame();
    wr_addr = 3'd5; wr_data = 8'h41; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("busy_n1", busy, 0);
    @(negedge clk);
    chk("busy_n2", {busy, rs, data}, {1'b1, 1'b0, 8'h80});
    wait_done("frame2_done", 1000);
    @(negedge clk);
    chk("busy_after_f2", busy, 0);

    mdl[7] = 8'h43;
    push_frame();
    wr_addr = 3'd7; wr_data = 8'h43; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (!(rs === 1'b0 && data === 8'hC0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_line1", data, 8'hC0);
    repeat (16) @(negedge clk);
    mdl[0] = 8'h42;
    push_frame();
    wr_addr = 3'd0; wr_data = 8'h42; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    wait_done("frame3a_done", 1000);
    @(negedge clk);
    chk("gap_idle", {busy, frame_done}, 0);
    @(negedge clk);
    chk("refire", {busy, rs, data}, {1'b1, 1'b0, 8'h80});
    wait_done("frame3b_done", 1000);
    @(negedge clk);
    chk("busy_after_f3", busy, 0);
    chk("sb_drained3", exp_q.size(), 0);

    push_frame();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    @(negedge clk);
    chk("refresh_busy", busy, 1);
    wait_done("frame4_done", 1000);
    @(negedge clk);
    chk("busy_after_f4", busy, 0);

    mdl[2] = 8'h44;
    push_frame();
    wr_addr = 3'd2; wr_data = 8'h44; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (!(rs === 1'b1 && enable === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pulse", {rs, enable}, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_kill", {enable, data}, 0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h20;
    push_init();
    push_frame();
    @(negedge clk);
    rst = 1'b0;
    wait_done("frame5_done", 1000);
    @(negedge clk);
    chk("busy_after_f5", busy, 0);

    exp4.push_back(8'h80);
    exp4.push_back(8'hC0);
    exp4.push_back(8'h94);
    exp4.push_back(8'hD4);
    xfer4 = 0;
    rst4 = 1'b0;
    n = 0;
    while (frame_done4 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("frame4l_done", frame_done4, 1);
    chk("xfers4", xfer4, 88);
    chk("line_cmds4_all", exp4.size(), 0);
    @(negedge clk);
    @(negedge clk);
    wr_addr4 = 7'd100; wr_data4 = 8'h41; wr_en4 = 1'b1;
    @(negedge clk);
    wr_en4 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | busy4;
    end
    chk("oor_ignored", seen, 0);

    chk("sb_final", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
